// File: rtl/path_length_engine.sv
// path_length_engine: streams N (x,y) points from the coordinate RAMs and reports the
// saturating Manhattan path length plus the longest hop and its index.
module path_length_engine #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 8,
    parameter int SUM_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W:0]    num_points,
    output logic [ADDR_W-1:0]  mem_address,
    input  logic [COORD_W-1:0] x_q,
    input  logic [COORD_W-1:0] y_q,
    output logic               busy,
    output logic               done,
    output logic [SUM_W-1:0]   total_len,
    output logic [COORD_W:0]   max_hop,
    output logic [ADDR_W-1:0]  max_hop_idx,
    output logic               overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
    state_t state, state_nx;
    logic [ADDR_W:0]    n;
    logic               vld;
    logic [ADDR_W-1:0]  k;
    logic [COORD_W-1:0] px, py, dx, dy;
    logic [COORD_W:0]   hop;
    logic [SUM_W:0]     sum;
    logic               last;
    // compare at ADDR_W+1 bits so N = 2**ADDR_W terminates without wrapping
    assign last = {1'b0, mem_address} == n - 1'b1;
    assign dx   = x_q > px ? x_q - px : px - x_q;
    assign dy   = y_q > py ? y_q - py : py - y_q;
    assign hop  = {1'b0, dx} + {1'b0, dy};
    assign sum  = {1'b0, total_len} + {{(SUM_W-COORD_W){1'b0}}, hop};
    assign busy = state != IDLE;
    assign done = state == FINISH;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = num_points < (ADDR_W+1)'(2) ? FINISH : RUN;
            RUN:     if (last) state_nx = DRAIN;
            DRAIN:   state_nx = FINISH;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n           <= '0;
            mem_address <= '0;
            vld         <= 1'b0;
            k           <= '0;
            px          <= '0;
            py          <= '0;
            total_len   <= '0;
            max_hop     <= '0;
            max_hop_idx <= '0;
            overflow    <= 1'b0;
        end else begin
            vld <= state == RUN;
            k   <= mem_address;
            if (state == IDLE && start) begin
                n           <= num_points;
                mem_address <= '0;
                total_len   <= '0;
                max_hop     <= '0;
                max_hop_idx <= '0;
                overflow    <= 1'b0;
            end
            if (state == RUN && !last) mem_address <= mem_address + 1'b1;
            // sample 0 only seeds the previous-point registers
            if (vld) begin
                px <= x_q;
                py <= y_q;
                if (k != '0) begin
                    total_len <= (overflow | sum[SUM_W]) ? '1 : sum[SUM_W-1:0];
                    overflow  <= overflow | sum[SUM_W];
                    if (hop > max_hop) begin
                        max_hop     <= hop;
                        max_hop_idx <= k;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_path_length_engine.sv
// tb_path_length_engine: randomized scoreboard bench; a reference model pushes expected
// results at start, a monitor pops and compares on every done pulse.
module tb_path_length_engine;
    localparam int AW = 8, CW = 8, SW = 16;
    logic          clk = 0, reset_n = 0, start = 0;
    logic [AW:0]   num_points = '0;
    logic [AW-1:0] mem_address;
    logic [CW-1:0] x_q, y_q;
    logic          busy, done;
    logic [SW-1:0] total_len;
    logic [CW:0]   max_hop;
    logic [AW-1:0] max_hop_idx;
    logic          overflow;
    int total = 0, bad = 0, cyc = 0;
    logic [CW-1:0] xm [256];
    logic [CW-1:0] ym [256];
    typedef struct {int tl; int mh; int mi; int ov; int dc;} exp_t;
    exp_t q[$];
    exp_t e;

    path_length_engine #(.ADDR_W(AW), .COORD_W(CW), .SUM_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_points(num_points),
        .mem_address(mem_address), .x_q(x_q), .y_q(y_q), .busy(busy), .done(done),
        .total_len(total_len), .max_hop(max_hop), .max_hop_idx(max_hop_idx),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        x_q <= xm[mem_address];
        y_q <= ym[mem_address];
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return a > b ? a - b : b - a;
    endfunction

    function automatic exp_t model(input int n, input int c0);
        exp_t r;
        int s = 0, h;
        r.mh = 0;
        r.mi = 0;
        for (int i = 1; i < n; i++) begin
            h = absd(int'(xm[i]), int'(xm[i-1])) + absd(int'(ym[i]), int'(ym[i-1]));
            s += h;
            if (h > r.mh) begin
                r.mh = h;
                r.mi = i;
            end
        end
        r.ov = s > 65535 ? 1 : 0;
        r.tl = r.ov ? 65535 : s;
        r.dc = n < 2 ? c0 : c0 + n + 1;
        return r;
    endfunction

    always @(negedge clk)
        if (reset_n && done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("total_len", int'(total_len), e.tl);
                chk("max_hop", int'(max_hop), e.mh);
                chk("max_hop_idx", int'(max_hop_idx), e.mi);
                chk("overflow", int'(overflow), e.ov);
                chk("done_cycle", cyc, e.dc);
                chk("busy_at_done", int'(busy), 1);
            end
        end

    task automatic zero_chk();
        chk("rst_mem_address", int'(mem_address), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_total_len", int'(total_len), 0);
        chk("rst_max_hop", int'(max_hop), 0);
        chk("rst_max_hop_idx", int'(max_hop_idx), 0);
        chk("rst_overflow", int'(overflow), 0);
    endtask

    task automatic run(input int n, input int poke, input int rst_at);
        int c0;
        @(negedge clk);
        num_points = n[AW:0];
        start = 1;
        c0 = cyc + 1;
        if (rst_at == 0) q.push_back(model(n, c0));
        @(negedge clk);
        start = 0;
        num_points = AW'($urandom);
        chk("busy_after_start", int'(busy), 1);
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        if (rst_at > 0) begin
            repeat (rst_at) @(negedge clk);
            reset_n = 0;
            #1 zero_chk();
            @(negedge clk);
            reset_n = 1;
        end
        for (int i = 0; i < n + 20 && (q.size() != 0 || busy); i++) @(negedge clk);
        chk("pending_after_run", q.size(), 0);
        q.delete();
        if (n < 2) chk("addr_short_run", int'(mem_address), 0);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            xm[i] = CW'($urandom);
            ym[i] = CW'($urandom);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            xm[i] = '0;
            ym[i] = '0;
        end
        repeat (3) @(negedge clk);
        zero_chk();
        reset_n = 1;
        xm[0] = 0;   ym[0] = 0;
        xm[1] = 3;   ym[1] = 4;
        xm[2] = 10;  ym[2] = 4;
        run(3, 0, 0);
        xm[0] = 200; ym[0] = 10;
        xm[1] = 5;   ym[1] = 250;
        run(2, 0, 0);
        run(1, 0, 0);
        run(0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            xm[i] = (i % 2) ? 8'd255 : 8'd0;
            ym[i] = xm[i];
        end
        run(256, 0, 0);
        fill(10);
        run(10, 4, 0);
        run(10, 0, 3);
        run(10, 0, 0);
        repeat (20) begin
            n = $urandom_range(0, 40);
            if ($urandom_range(0, 7) == 0) n = $urandom_range(200, 256);
            fill(n);
            run(n, (n > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
